trigger_link_rx_decoder: RTL and testbench

//  Receive end of the GEM trigger fiber link: takes 8b/10b-decoded 16-bit words from a GTX receiver
//  (4 words per BX at 160 MHz), aligns to the K-char frame start, checks framing and latency-marker period,
//  and recovers the four 14-bit clusters plus overflow. Used on the CSC/uTCA side and in OH loopback tests.

---
 rtl/gem_trig_link_pkg.sv | 39 +++
 rtl/trigger_link_frame_checker.sv | 75 +++++++
 rtl/trigger_link_rx_decoder.sv | 159 +++++++++++++++
 tb/tb_trigger_link_rx_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gem_trig_link_pkg.sv
// Shared definitions for the GEM trigger fiber link: K-characters, frame geometry and link state.
// Used by both the TX framer and the RX decoder.
package gem_trig_link_pkg;

  localparam logic [7:0] K_NORM     = 8'hBC;
  localparam logic [7:0] K_OVF      = 8'hF7;
  localparam logic [7:0] K_MARK     = 8'hFC;
  localparam logic [7:0] K_MARK_OVF = 8'h7C;

  localparam int FRAME_WORDS = 4;
  localparam int PAYLOAD_W   = 56;
  localparam int CLUSTER_W   = 14;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_SYNCING = 2'd1,
    ST_LOCKED  = 2'd2
  } link_state_t;

  typedef struct packed {
    logic valid;
    logic ovf;
    logic mark;
  } kdec_t;

  function automatic kdec_t k_decode(input logic [7:0] k);
    kdec_t d;
    d = '0;
    case (k)
      K_NORM:     d.valid = 1'b1;
      K_OVF:      begin d.valid = 1'b1; d.ovf = 1'b1; end
      K_MARK:     begin d.valid = 1'b1; d.mark = 1'b1; end
      K_MARK_OVF: begin d.valid = 1'b1; d.ovf = 1'b1; d.mark = 1'b1; end
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trigger_link_frame_checker.sv
// Word counter, payload capture and per-frame framing check for the trigger link receiver.
// The frame verdict and payload are presented combinationally while w3 is on the bus.
module trigger_link_frame_checker
  import gem_trig_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          rx_data,
  input  logic [1:0]           rx_isk,
  input  logic                 rx_valid,
  input  logic                 search,
  output logic                 start,
  output logic                 frame_done,
  output logic                 frame_bad,
  output logic                 frame_ovf,
  output logic                 frame_mark,
  output logic [PAYLOAD_W-1:0] frame_payload
);

  logic [1:0]  wcnt;
  logic [39:0] pay_q;
  logic        w0_bad;
  logic        isk_bad;
  logic        ovf_q;
  logic        mark_q;
  kdec_t       kd;
  logic        w0_ok;

  assign kd    = k_decode(rx_data[7:0]);
  assign w0_ok = (rx_isk == 2'b01) && kd.valid;
  assign start = search && rx_valid && w0_ok;

  // While searching, wcnt is always 0, so a recognised w0 takes the normal w0 path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      pay_q   <= '0;
      w0_bad  <= 1'b0;
      isk_bad <= 1'b0;
      ovf_q   <= 1'b0;
      mark_q  <= 1'b0;
    end else if (!rx_valid) begin
      wcnt <= '0;
    end else if (search && !w0_ok) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 2'd1;
      case (wcnt)
        2'd0: begin
          pay_q[7:0] <= rx_data[15:8];
          w0_bad     <= ~w0_ok;
          ovf_q      <= kd.ovf;
          mark_q     <= kd.mark;
          isk_bad    <= 1'b0;
        end
        2'd1: begin
          pay_q[23:8] <= rx_data;
          isk_bad     <= |rx_isk;
        end
        2'd2: begin
          pay_q[39:24] <= rx_data;
          isk_bad      <= isk_bad | (|rx_isk);
        end
        default: ;
      endcase
    end
  end

  assign frame_done    = !search && (wcnt == 2'd3);
  assign frame_bad     = w0_bad | isk_bad | (|rx_isk);
  assign frame_ovf     = ovf_q;
  assign frame_mark    = mark_q;
  assign frame_payload = {rx_data, pay_q};

endmodule

// File: rtl/trigger_link_rx_decoder.sv
// Receive end of the GEM trigger fiber link: frame alignment FSM, latency-marker check,
// saturating error counter and registered cluster outputs.
module trigger_link_rx_decoder
  import gem_trig_link_pkg::*;
#(
  parameter int LOCK_FRAMES   = 8,
  parameter int UNLOCK_ERRS   = 4,
  parameter int MARKER_PERIOD = 128,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_160,
  input  logic                     reset,
  input  logic [15:0]              rx_data,
  input  logic [1:0]               rx_isk,
  input  logic                     rx_valid,
  output logic [13:0]              cluster0,
  output logic [13:0]              cluster1,
  output logic [13:0]              cluster2,
  output logic [13:0]              cluster3,
  output logic                     overflow,
  output logic                     data_valid,
  output logic                     bx0,
  output logic                     locked,
  output logic                     marker_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int MW = $clog2(MARKER_PERIOD);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  link_state_t          state;
  logic [GW-1:0]        good_cnt;
  logic [BW-1:0]        bad_cnt;
  logic [MW-1:0]        mk_cnt;
  logic                 mk_seen;

  logic                 start;
  logic                 frame_done;
  logic                 frame_bad;
  logic                 frame_ovf;
  logic                 frame_mark;
  logic [PAYLOAD_W-1:0] frame_payload;

  logic                 content_good;
  logic                 frame_eval;
  logic                 mk_err_c;
  logic                 bad_c;
  logic                 good_c;

  trigger_link_frame_checker u_checker (
    .clk           (clk_160),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_isk        (rx_isk),
    .rx_valid      (rx_valid),
    .search        (state == ST_SEARCH),
    .start         (start),
    .frame_done    (frame_done),
    .frame_bad     (frame_bad),
    .frame_ovf     (frame_ovf),
    .frame_mark    (frame_mark),
    .frame_payload (frame_payload)
  );

  // A framing error on w3 still counts when rx_valid drops in the same cycle;
  // an otherwise clean frame cut short by rx_valid is simply discarded.
  assign content_good = frame_done && !frame_bad && rx_valid;
  assign frame_eval   = frame_done && (rx_valid || frame_bad);
  assign mk_err_c     = content_good && mk_seen &&
                        (frame_mark ? (mk_cnt != '0) : (mk_cnt == '0));
  assign bad_c        = frame_eval && (frame_bad || ((state == ST_LOCKED) && mk_err_c));
  assign good_c       = content_good && !bad_c;

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk_160 or posedge reset) begin
    if (reset) begin
      state      <= ST_SEARCH;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      mk_cnt     <= '0;
      mk_seen    <= 1'b0;
      cluster0   <= '0;
      cluster1   <= '0;
      cluster2   <= '0;
      cluster3   <= '0;
      overflow   <= 1'b0;
      data_valid <= 1'b0;
      bx0        <= 1'b0;
      marker_err <= 1'b0;
      err_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      bx0        <= 1'b0;
      marker_err <= mk_err_c;

      if (bad_c && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);

      // Marker frame is slot 0; the counter names the slot of the next frame.
      if (frame_eval) begin
        if (content_good && frame_mark) begin
          mk_cnt  <= MW'(1);
          mk_seen <= 1'b1;
        end else begin
          mk_cnt <= mk_cnt + MW'(1);
        end
      end

      if (!rx_valid) begin
        state <= ST_SEARCH;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (start) begin
              state    <= ST_SYNCING;
              good_cnt <= '0;
              bad_cnt  <= '0;
              mk_cnt   <= '0;
              mk_seen  <= 1'b0;
            end
          end
          ST_SYNCING: begin
            if (bad_c) begin
              state <= ST_SEARCH;
            end else if (good_c) begin
              if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                state   <= ST_LOCKED;
                bad_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end
          end
          ST_LOCKED: begin
            if (bad_c) begin
              if (bad_cnt == BW'(UNLOCK_ERRS - 1))
                state <= ST_SEARCH;
              else
                bad_cnt <= bad_cnt + BW'(1);
            end else if (good_c) begin
              bad_cnt    <= '0;
              data_valid <= 1'b1;
              bx0        <= frame_mark;
              overflow   <= frame_ovf;
              cluster0   <= frame_payload[13:0];
              cluster1   <= frame_payload[27:14];
              cluster2   <= frame_payload[41:28];
              cluster3   <= frame_payload[55:42];
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_link_rx_decoder.sv
// Directed bench for trigger_link_rx_decoder; a second instance with a 3-bit error counter
// shares the stimulus to exercise counter saturation.
module tb_trigger_link_rx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rx_data;
  logic [1:0]  rx_isk;
  logic        rx_valid;

  logic [13:0] cluster0, cluster1, cluster2, cluster3;
  logic        overflow, data_valid, bx0, locked, marker_err;
  logic [15:0] err_cnt;

  logic [13:0] s_cluster0, s_cluster1, s_cluster2, s_cluster3;
  logic        s_overflow, s_data_valid, s_bx0, s_locked, s_marker_err;
  logic [2:0]  s_err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trigger_link_rx_decoder dut (
    .clk_160(clk), .reset(reset), .rx_data(rx_data), .rx_isk(rx_isk), .rx_valid(rx_valid),
    .cluster0(cluster0), .cluster1(cluster1), .cluster2(cluster2), .cluster3(cluster3),
    .overflow(overflow), .data_valid(data_valid), .bx0(bx0), .locked(locked),
    .marker_err(marker_err), .err_cnt(err_cnt)
  );

  trigger_link_rx_decoder #(.ERR_CNT_WIDTH(3)) dut_sat (
    .clk_160(clk), .reset(reset), .rx_data(rx_data), .rx_isk(rx_isk), .rx_valid(rx_valid),
    .cluster0(s_cluster0), .cluster1(s_cluster1), .cluster2(s_cluster2), .cluster3(s_cluster3),
    .overflow(s_overflow), .data_valid(s_data_valid), .bx0(s_bx0), .locked(s_locked),
    .marker_err(s_marker_err), .err_cnt(s_err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] pl(input logic [13:0] c0, input logic [13:0] c1,
                                     input logic [13:0] c2, input logic [13:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [55:0] clus();
    return {cluster3, cluster2, cluster1, cluster0};
  endfunction

  task automatic put(input logic [15:0] d, input logic [1:0] k, input logic v);
    rx_data  = d;
    rx_isk   = k;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  // bad_word 1..3 sets isk=01 on that payload word.
  task automatic send_frame(input logic [7:0] k, input logic [55:0] p, input int bad_word);
    put({p[7:0], k}, 2'b01, 1'b1);
    put(p[23:8],  (bad_word == 1) ? 2'b01 : 2'b00, 1'b1);
    put(p[39:24], (bad_word == 2) ? 2'b01 : 2'b00, 1'b1);
    put(p[55:40], (bad_word == 3) ? 2'b01 : 2'b00, 1'b1);
  endtask

  initial begin
    logic [55:0] p;
    logic [55:0] last_good;
    int me;
    int bxs;

    reset = 1'b1; rx_data = '0; rx_isk = '0; rx_valid = 1'b0;
    #23;
    chk("rst_clusters", clus(), 56'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err", err_cnt, 16'h0);
    chk("rst_dv", data_valid, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Lock on 8 good frames, data from the 9th
    for (int f = 1; f <= 10; f++) begin
      p = (f == 10) ? pl(14'h1234, 14'h0ABC, 14'h3001, 14'h2222) : pl(14'h1, 14'h2, 14'h3, 14'h4);
      send_frame((f == 1) ? 8'hFC : 8'hBC, p, 0);
      if (f == 7) chk("lock_f7", locked, 1'b0);
      if (f == 8) begin chk("lock_f8", locked, 1'b1); chk("dv_f8", data_valid, 1'b0); end
      if (f >= 9) begin
        chk("dv_f9_10", data_valid, 1'b1);
        chk("clus_f9_10", clus(), p);
        chk("bx0_f9_10", bx0, 1'b0);
        chk("ovf_f9_10", overflow, 1'b0);
      end
    end
    chk("err_after_lock", err_cnt, 16'h0);
    last_good = p;

    // Bad frames in LOCKED
    send_frame(8'hBC, pl(14'h7, 14'h7, 14'h7, 14'h7), 2);
    chk("bad_dv", data_valid, 1'b0);
    chk("bad_err1", err_cnt, 16'd1);
    chk("bad_locked", locked, 1'b1);
    chk("bad_held", clus(), last_good);
    p = pl(14'h11, 14'h22, 14'h33, 14'h44);
    send_frame(8'hBC, p, 0);
    chk("good_after_bad", data_valid, 1'b1);
    send_frame(8'hBC, p, 3);
    send_frame(8'h1C, p, 0);
    send_frame(8'hBC, p, 1);
    chk("three_bad_locked", locked, 1'b1);
    chk("three_bad_err", err_cnt, 16'd4);
    send_frame(8'hBC, p, 2);
    chk("four_bad_unlock", locked, 1'b0);
    chk("four_bad_err", err_cnt, 16'd5);

    // Misaligned restart: tail of a frame and a bogus K-char ignored in SEARCH
    put(p[39:24], 2'b00, 1'b1);
    put(p[55:40], 2'b00, 1'b1);
    put({8'h55, 8'h1C}, 2'b01, 1'b1);
    chk("search_no_err", err_cnt, 16'd5);
    for (int f = 1; f <= 9; f++) begin
      p = pl(14'h5, 14'h6, 14'h7, 14'(f));
      send_frame(8'hBC, p, 0);
      if (f == 7) chk("realign_f7", locked, 1'b0);
      if (f == 8) chk("realign_f8", locked, 1'b1);
      if (f == 9) begin
        chk("realign_dv", data_valid, 1'b1);
        chk("realign_clus", clus(), p);
      end
    end
    chk("realign_err", err_cnt, 16'd5);

    // Overflow and marker K-chars
    send_frame(8'hF7, 56'hFF_FFFF_FFFF_FFFF, 0);
    chk("ovf_dv", data_valid, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_clus", clus(), {4{14'h3FFF}});
    chk("ovf_bx0", bx0, 1'b0);
    p = pl(14'h0AA, 14'h155, 14'h2AA, 14'h3C3);
    send_frame(8'h7C, p, 0);
    chk("mkovf_bx0", bx0, 1'b1);
    chk("mkovf_ovf", overflow, 1'b1);
    chk("mkovf_clus", clus(), p);
    chk("mkovf_merr", marker_err, 1'b0);

    // Early marker at slot 120
    me = 0;
    for (int f = 1; f <= 119; f++) begin
      send_frame(8'hBC, pl(14'(f), 14'h0, 14'h0, 14'h0), 0);
      if (marker_err) me++;
    end
    chk("no_merr_pre", me, 0);
    send_frame(8'hFC, pl(14'h9, 14'h9, 14'h9, 14'h9), 0);
    chk("early_merr", marker_err, 1'b1);
    chk("early_dv", data_valid, 1'b0);
    chk("early_err", err_cnt, 16'd6);
    chk("early_locked", locked, 1'b1);
    me = 0; bxs = 0;
    for (int f = 1; f <= 127; f++) begin
      send_frame(8'hBC, pl(14'h0, 14'(f), 14'h0, 14'h0), 0);
      if (marker_err) me++;
      if (bx0) bxs++;
    end
    chk("resync_no_merr", me, 0);
    chk("resync_no_bx0", bxs, 0);
    p = pl(14'h3, 14'h2, 14'h1, 14'h0);
    send_frame(8'hFC, p, 0);
    chk("resync_bx0", bx0, 1'b1);
    chk("resync_dv", data_valid, 1'b1);
    chk("resync_merr", marker_err, 1'b0);

    // Saturation of the narrow counter
    send_frame(8'hBC, p, 2);
    chk("sat_main7", err_cnt, 16'd7);
    chk("sat_small7", s_err_cnt, 3'd7);
    send_frame(8'hBC, p, 0);
    send_frame(8'hBC, p, 1);
    send_frame(8'hBC, p, 0);
    send_frame(8'hBC, p, 3);
    chk("sat_main9", err_cnt, 16'd9);
    chk("sat_small_hold", s_err_cnt, 3'd7);
    chk("sat_locked", locked, 1'b1);

    // rx_valid drop: unlock, no error, outputs held
    put(16'h0, 2'b00, 1'b0);
    chk("rxv_unlock", locked, 1'b0);
    chk("rxv_err", err_cnt, 16'd9);
    chk("rxv_held", clus(), p);

    // Asynchronous reset mid-frame
    put({8'h12, 8'hBC}, 2'b01, 1'b1);
    put(16'h3456, 2'b00, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_clus", clus(), 56'h0);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_err", err_cnt, 16'h0);
    chk("arst_small_err", s_err_cnt, 3'h0);
    chk("arst_dv", data_valid, 1'b0);
    #4 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_locked", locked, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
